irq_period_monitor: RTL

PL-side interrupt monitor sitting at the receiving end of the periodic interrupt generator's pulse line (e.g. the 3 ms or 0.5 ms tick) alongside the PS interrupt input.
- Edge-detects the interrupt pulse, holds a pending flag until the PS acknowledges it, and counts interrupts raised while one was already pending.
- Measures the cycle count between consecutive rising edges and flags period deviation and loss of the tick.

---
 rtl/irq_period_monitor.sv | 127 ++++++++++++
 1 files changed

// File: rtl/irq_period_monitor.sv
// Periodic interrupt monitor: edge-detects the tick, tracks PS pending/ack and overruns,
// and measures tick period with deviation/loss flags. Define IRQ_SYNC_EN to add an input synchronizer.
module irq_period_monitor #(
  parameter int Sys_period  = 5,
  parameter int Time_expect = 3_000_000,
  parameter int Expect_cnt  = Time_expect / Sys_period,
  parameter int Tol_cnt     = 16,
  parameter int Width_cnt   = 20
) (
  input  logic                 Sys_clk,
  input  logic                 Rst_n,
  input  logic                 Irq_in,
  input  logic                 Irq_ack,
  input  logic                 Clr_err,
  output logic                 Irq_pending,
  output logic [Width_cnt-1:0] Period_cnt,
  output logic                 Period_valid,
  output logic                 Period_err,
  output logic                 Timeout,
  output logic [7:0]           Overrun_cnt
);

  localparam logic [1:0] St_idle = 2'd0;
  localparam logic [1:0] St_run  = 2'd1;
  localparam logic [1:0] St_lost = 2'd2;

  localparam logic [Width_cnt-1:0] Hi_lim = Width_cnt'(Expect_cnt + Tol_cnt);
  localparam logic [Width_cnt-1:0] Lo_lim = Width_cnt'(Expect_cnt - Tol_cnt);

  logic                 irq_s;
  logic                 irq_d1;
  logic                 rise;
  logic [1:0]           state;
  logic [Width_cnt-1:0] counter;
  logic [Width_cnt-1:0] cnt_inc;
  logic                 err_set;
  logic                 timeout_set;
  logic                 overrun_set;
  logic [7:0]           ovr_base;
  logic [7:0]           ovr_next;

`ifdef IRQ_SYNC_EN
  logic sync_p0;
  logic sync_p1;

  // Input synchronizer stage
  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= Irq_in;
      sync_p1 <= sync_p0;
    end
  end

  assign irq_s = sync_p1;
`else
  assign irq_s = Irq_in;
`endif

  always_comb begin
    rise        = irq_s & ~irq_d1;
    cnt_inc     = (&counter) ? counter : counter + Width_cnt'(1);
    err_set     = (state == St_run) && rise && ((cnt_inc < Lo_lim) || (cnt_inc > Hi_lim));
    timeout_set = (state == St_run) && !rise && (cnt_inc == Hi_lim);
    overrun_set = rise && Irq_pending && !Irq_ack;
    // Clear takes effect first so a same-cycle overrun lands on a zeroed count
    ovr_base    = Clr_err ? 8'd0 : Overrun_cnt;
    ovr_next    = (overrun_set && (ovr_base != 8'hFF)) ? ovr_base + 8'd1 : ovr_base;
  end

  // Edge detect, period measurement and status stage
  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n) begin
      irq_d1       <= 1'b0;
      state        <= St_idle;
      counter      <= '0;
      Period_cnt   <= '0;
      Period_valid <= 1'b0;
      Period_err   <= 1'b0;
      Timeout      <= 1'b0;
      Overrun_cnt  <= 8'd0;
      Irq_pending  <= 1'b0;
    end else begin
      irq_d1       <= irq_s;
      Period_valid <= 1'b0;

      case (state)
        St_idle: begin
          counter <= '0;
          if (rise) state <= St_run;
        end
        St_run: begin
          if (rise) begin
            Period_cnt   <= cnt_inc;
            Period_valid <= 1'b1;
            counter      <= '0;
          end else begin
            counter <= cnt_inc;
            if (cnt_inc == Hi_lim) state <= St_lost;
          end
        end
        St_lost: begin
          if (rise) begin
            counter <= '0;
            state   <= St_run;
          end else begin
            counter <= cnt_inc;
          end
        end
        default: begin
          counter <= '0;
          state   <= St_idle;
        end
      endcase

      if (rise)         Irq_pending <= 1'b1;
      else if (Irq_ack) Irq_pending <= 1'b0;

      Period_err  <= err_set | (Period_err & ~Clr_err);
      Timeout     <= timeout_set | (Timeout & ~Clr_err);
      Overrun_cnt <= ovr_next;
    end
  end

endmodule
